// File: rtl/low_freq_counter_bin.sv
// -----------------------------------------------------------------------------
// low_freq_counter_bin
// Period-based frequency meter for slow signals (about 1 Hz .. 1 MHz).
// After a start request the block counts system-clock cycles between two
// consecutive rising edges of i_signal, then divides CLK_FREQ*1000 by that
// period with a sequential restoring divider (one quotient bit per clock).
// The result is the measured frequency in millihertz.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      start request, only honoured while o_ready is high
//   i_signal     measured signal, asynchronous to i_clk
//   o_frequency  last measured frequency in mHz (saturates at 0xFFFF_FFFF)
//   o_ready      high while idle and accepting i_start
//   o_done       one-cycle pulse when o_frequency has just been updated
// -----------------------------------------------------------------------------
module low_freq_counter_bin #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned DVND_W   = 37
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_signal,
    output logic [31:0] o_frequency,
    output logic        o_ready,
    output logic        o_done
);

    // CLK_FREQ*1000 does not fit in 32 bits, so build it in 64 bits first.
    localparam logic [63:0]       DIVIDEND_WIDE = 64'(CLK_FREQ) * 64'd1000;
    localparam logic [DVND_W-1:0] DIVIDEND      = DIVIDEND_WIDE[DVND_W-1:0];
    localparam int                ITER_W        = $clog2(DVND_W + 1);
    localparam logic [ITER_W-1:0] ITER_INIT     = ITER_W'(DVND_W);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FIRST = 3'd1,
        COUNT      = 3'd2,
        DIV_INIT   = 3'd3,
        DIV        = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                sync1_r;
    logic                sync2_r;
    logic                dly_r;
    logic                rise_s;
    logic [31:0]         count_r;
    logic [31:0]         period_r;
    logic [DVND_W-1:0]   dvnd_r;
    logic [DVND_W-1:0]   quo_r;
    logic [DVND_W-1:0]   rem_r;
    logic [ITER_W-1:0]   iter_r;
    logic [DVND_W-1:0]   divisor_s;
    logic [DVND_W-1:0]   rem_shift_s;
    logic [DVND_W-1:0]   rem_diff_s;
    logic                ge_s;
    logic [DVND_W-1:0]   rem_step_s;
    logic [DVND_W-1:0]   quo_step_s;
    logic [31:0]         result_s;
    logic [31:0]         freq_r;
    logic                ready_r;
    logic                done_r;

    // Saturating increment for the 32-bit cycle counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return 32'hFFFF_FFFF;
        end else begin
            return value + 32'd1;
        end
    endfunction

    // Clamp a full-width quotient to the 32-bit output range.
    function automatic logic [31:0] sat_quotient(input logic [DVND_W-1:0] quo);
        if (quo[DVND_W-1:32] != '0) begin
            return 32'hFFFF_FFFF;
        end else begin
            return quo[31:0];
        end
    endfunction

    assign rise_s = sync2_r & ~dly_r;

    // Input synchronizer plus delay flop for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            dly_r   <= 1'b0;
        end else begin
            sync1_r <= i_signal;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
        end
    end

    // One restoring-division step. The partial remainder is always below the
    // divisor (< 2^32), so its top bit only matters as a guard: if it were set,
    // the shifted value would certainly exceed the divisor.
    always_comb begin
        divisor_s   = {{(DVND_W-32){1'b0}}, period_r};
        rem_shift_s = {rem_r[DVND_W-2:0], dvnd_r[DVND_W-1]};
        rem_diff_s  = rem_shift_s - divisor_s;
        ge_s        = rem_r[DVND_W-1] | (rem_shift_s >= divisor_s);
        if (ge_s) begin
            rem_step_s = rem_diff_s;
        end else begin
            rem_step_s = rem_shift_s;
        end
        quo_step_s = {quo_r[DVND_W-2:0], ge_s};
        if (period_r == 32'd0) begin
            result_s = 32'hFFFF_FFFF;
        end else begin
            result_s = sat_quotient(quo_step_s);
        end
    end

    // Next-state logic of the measurement sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s = WAIT_FIRST;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_FIRST: begin
                if (rise_s) begin
                    state_s = COUNT;
                end else begin
                    state_s = WAIT_FIRST;
                end
            end
            COUNT: begin
                if (rise_s) begin
                    state_s = DIV_INIT;
                end else begin
                    state_s = COUNT;
                end
            end
            DIV_INIT: state_s = DIV;
            DIV: begin
                if (iter_r == ITER_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = DIV;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, counters, divider datapath and registered outputs.
    // The result is captured on the final divide step so that o_done and the
    // new o_frequency appear together during DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            count_r  <= 32'd0;
            period_r <= 32'd0;
            dvnd_r   <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            iter_r   <= '0;
            freq_r   <= 32'd0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
            done_r  <= (state_s == DONE);
            case (state_r)
                WAIT_FIRST: begin
                    if (rise_s) begin
                        count_r <= 32'd0;
                    end
                end
                COUNT: begin
                    count_r <= sat_inc(count_r);
                    if (rise_s) begin
                        period_r <= sat_inc(count_r);
                    end
                end
                DIV_INIT: begin
                    dvnd_r <= DIVIDEND;
                    quo_r  <= '0;
                    rem_r  <= '0;
                    iter_r <= ITER_INIT;
                end
                DIV: begin
                    dvnd_r <= {dvnd_r[DVND_W-2:0], 1'b0};
                    rem_r  <= rem_step_s;
                    quo_r  <= quo_step_s;
                    iter_r <= iter_r - ITER_W'(1);
                    if (state_s == DONE) begin
                        freq_r <= result_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_frequency = freq_r;
    assign o_ready     = ready_r;
    assign o_done      = done_r;

endmodule

// File: tb/tb_low_freq_counter_bin.sv
// -----------------------------------------------------------------------------
// Testbench for low_freq_counter_bin. Stimulus produces edge pairs with exact
// clock-cycle spacing and pushes floor(1e11 / period) (clamped to 32 bits)
// into a scoreboard queue; an independent monitor pops and compares on every
// o_done pulse.
// -----------------------------------------------------------------------------
module tb_low_freq_counter_bin;

    localparam longint unsigned DIVIDEND = 64'd100_000_000_000;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_signal;
    logic [31:0] o_frequency;
    logic        o_ready;
    logic        o_done;

    logic [31:0] expq[$];
    int          n_vec;
    int          n_err;
    int          n_push;
    int          n_done;

    low_freq_counter_bin #(
        .CLK_FREQ(100_000_000),
        .DVND_W  (37)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_signal   (i_signal),
        .o_frequency(o_frequency),
        .o_ready    (o_ready),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: frequency in mHz for a period of n clock cycles.
    function automatic logic [31:0] model(input int unsigned n);
        longint unsigned q;
        q = DIVIDEND / longint'(n);
        if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every o_done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            logic [31:0] e;
            n_done++;
            n_vec++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got o_done with frequency %0d, expected no pulse", o_frequency);
            end else begin
                e = expq.pop_front();
                if (o_frequency !== e) begin
                    n_err++;
                    $display("FAIL frequency: got %0d, expected %0d", o_frequency, e);
                end
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk) #1 i_start = 1'b1;
        @(posedge clk) #1 i_start = 1'b0;
    endtask

    // Two rising edges exactly n cycles apart. mode 0: normal (push result),
    // mode 1: reset pulse mid-COUNT (no result), mode 2: no result pushed.
    task automatic edge_pair(input int unsigned n, input bit poke, input int mode);
        int unsigned w;
        @(posedge clk) #1 i_signal = 1'b1;
        w = $urandom_range(n - 1, 1);
        for (int k = 1; k < int'(n); k++) begin
            @(posedge clk) #1;
            if (k == int'(w)) i_signal = 1'b0;
            i_start = poke && (k == int'(n / 2));
            i_rst   = (mode == 1) && (k == int'(n / 2));
        end
        @(posedge clk) #1;
        i_signal = 1'b1;
        i_start  = 1'b0;
        i_rst    = 1'b0;
        if (mode == 0) begin
            expq.push_back(model(n));
            n_push++;
        end
        @(posedge clk) #1 i_signal = 1'b0;
    endtask

    task automatic wait_done(input bit poke_div);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 120 && !seen; k++) begin
            @(negedge clk);
            if (o_done === 1'b1) seen = 1'b1;
            if (poke_div && k == 10) i_start = 1'b1;
            if (k == 11) i_start = 1'b0;
        end
        i_start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("ready_after_done", {31'd0, o_ready}, 32'd1);
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
    endtask

    task automatic measure(input int unsigned n, input bit poke_cnt, input bit poke_div);
        start_pulse();
        repeat (3) @(posedge clk);
        edge_pair(n, poke_cnt, 0);
        wait_done(poke_div);
    endtask

    task automatic check_reset_values(input string tag);
        repeat (60) @(negedge clk);
        check({tag, "_freq"}, o_frequency, 32'd0);
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_push = 0; n_done = 0;
        i_rst = 1'b1; i_start = 1'b0; i_signal = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, o_ready}, 32'd1);
        check("reset_freq", o_frequency, 32'd0);
        check("reset_done", {31'd0, o_done}, 32'd0);

        // Armed with no edges: must sit waiting with o_ready low.
        start_pulse();
        repeat (12) @(negedge clk);
        check("wait_first_ready", {31'd0, o_ready}, 32'd0);
        edge_pair(100, 1'b0, 0);
        wait_done(1'b0);

        // Directed periods: 1 us, saturation boundary, minimum spacing.
        measure(100, 1'b0, 1'b0);
        measure(23, 1'b0, 1'b0);
        measure(24, 1'b0, 1'b0);
        measure(2, 1'b0, 1'b0);
        measure(3, 1'b0, 1'b0);
        measure(2500, 1'b1, 1'b1);

        // Randomized back-to-back periods with stray start pulses.
        for (int i = 0; i < 16; i++) begin
            int unsigned n;
            n = $urandom_range(2000, 2);
            measure(n, n >= 20, $urandom_range(1, 0) == 1);
        end

        // Reset during COUNT aborts without a result.
        start_pulse();
        repeat (3) @(posedge clk);
        edge_pair(200, 1'b0, 1);
        check_reset_values("abort_count");
        measure(100, 1'b0, 1'b0);

        // Reset during DIV aborts without a result.
        start_pulse();
        repeat (3) @(posedge clk);
        edge_pair(100, 1'b0, 2);
        repeat (12) @(posedge clk);
        #1 i_rst = 1'b1;
        @(posedge clk) #1 i_rst = 1'b0;
        check_reset_values("abort_div");
        measure(100, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("pending_results", expq.size(), 32'd0);
        check("done_count", n_done, n_push);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
